// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host link: FSM state encoding, default geometry
// and a counter-width helper.
package tpu_pkg;

  localparam int D_W_DEF  = 8;
  localparam int N_DEF    = 2;
  localparam int WORD_DEF = 2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SHIFT  = 3'd1;
  localparam logic [2:0] INIT   = 3'd2;
  localparam logic [2:0] WAIT_Z = 3'd3;
  localparam logic [2:0] RECV   = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;

  // Bits needed to count 0..n-1 (never less than one).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tpu_link_ser.sv
// Parallel-load, MSB-first shift register with a bit counter; last flags the
// final bit of the loaded word.
module tpu_link_ser
  import tpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  output logic         dout,
  output logic         last
);

  localparam int CW = cnt_w(W);

  logic [W-1:0]  sh_reg;
  logic [CW-1:0] cnt_reg;

  // A load in the final bit cycle wins over the shift so words chain without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      sh_reg  <= din;
      cnt_reg <= '0;
    end else if (shift) begin
      sh_reg  <= sh_reg << 1;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign dout = sh_reg[W-1];
  assign last = (cnt_reg == CW'(W - 1));

endmodule

// File: rtl/tpu_host_link.sv
// Host-side link for a serially loaded systolic TPU: serialises operand words, pulses init,
// deserialises the result. Define TPU_LINK_TIMEOUT_EN to enable the result-wait watchdog.
module tpu_host_link
  import tpu_pkg::*;
#(
  parameter int D_W         = D_W_DEF,
  parameter int N           = N_DEF,
  parameter int WORD        = WORD_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [N*D_W-1:0]       op_x_flat,
  input  logic [N*D_W-1:0]       op_y_flat,
  output logic                   data_in_x,
  output logic                   data_in_y,
  output logic                   load_en,
  output logic                   init,
  input  logic                   data_out_z,
  input  logic                   tx_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N*N*2*D_W-1:0]   res_z_flat,
  output logic                   err_timeout
);

  localparam int WW  = N * D_W;
  localparam int RW  = N * N * 2 * D_W;
  localparam int WCW = cnt_w(WORD);
  localparam int RCW = cnt_w(RW);

  logic [2:0]     state_reg, state_next;
  logic           gap_reg, gap_next;
  logic [WCW-1:0] word_reg, word_next;
  logic [RCW-1:0] rx_cnt_reg;
  logic [RW-1:0]  res_reg;

  logic hs, shift_on, bit_last, last_x, last_y, dx, dy;
  logic final_word, cap, rx_last, timeout;

  assign final_word = (word_reg == WCW'(WORD - 1));
  assign shift_on   = (state_reg == SHIFT) && !gap_reg;
  assign bit_last   = last_x && last_y;
  assign op_ready   = (state_reg == IDLE) ||
                      ((state_reg == SHIFT) && (gap_reg || (bit_last && !final_word)));
  assign hs         = op_valid && op_ready;
  assign cap        = tx_ready && ((state_reg == WAIT_Z) || (state_reg == RECV));
  assign rx_last    = (rx_cnt_reg == RCW'(RW - 1));

  tpu_link_ser #(.W(WW)) u_ser_x (
    .clk(clk), .rst(rst), .load(hs), .din(op_x_flat), .shift(shift_on), .dout(dx), .last(last_x)
  );

  tpu_link_ser #(.W(WW)) u_ser_y (
    .clk(clk), .rst(rst), .load(hs), .din(op_y_flat), .shift(shift_on), .dout(dy), .last(last_y)
  );

  // gap_reg marks a stalled word boundary inside SHIFT: outputs idle, waiting for the host.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    word_next  = word_reg;
    case (state_reg)
      IDLE: begin
        if (hs) begin
          state_next = SHIFT;
          gap_next   = 1'b0;
          word_next  = '0;
        end
      end
      SHIFT: begin
        if (gap_reg) begin
          if (hs) begin
            gap_next  = 1'b0;
            word_next = word_reg + 1'b1;
          end
        end else if (bit_last) begin
          if (final_word)  state_next = INIT;
          else if (hs)     word_next  = word_reg + 1'b1;
          else             gap_next   = 1'b1;
        end
      end
      INIT:   state_next = WAIT_Z;
      WAIT_Z, RECV: begin
        if (cap)          state_next = rx_last ? HOLD : RECV;
        else if (timeout) state_next = IDLE;
      end
      HOLD: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gap_reg   <= 1'b0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
      word_reg  <= word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_reg <= '0;
      res_reg    <= '0;
    end else if (state_reg == INIT) begin
      rx_cnt_reg <= '0;
    end else if (cap) begin
      res_reg    <= {res_reg[RW-2:0], data_out_z};
      rx_cnt_reg <= rx_cnt_reg + 1'b1;
    end
  end

`ifdef TPU_LINK_TIMEOUT_EN
  localparam int TCW = cnt_w(TIMEOUT_CYC);
  logic [TCW-1:0] to_cnt_reg;
  logic           err_reg;

  assign timeout = (state_reg == WAIT_Z) && !tx_ready && (to_cnt_reg == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= timeout;
      if ((state_reg == WAIT_Z) && !tx_ready) to_cnt_reg <= to_cnt_reg + 1'b1;
      else                                    to_cnt_reg <= '0;
    end
  end

  assign err_timeout = err_reg;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign load_en    = shift_on;
  assign data_in_x  = shift_on && dx;
  assign data_in_y  = shift_on && dy;
  assign init       = (state_reg == INIT);
  assign res_valid  = (state_reg == HOLD);
  assign res_z_flat = res_reg;

endmodule

// File: tb/tb_tpu_host_link.sv
// Scoreboard bench for tpu_host_link: stimulus pushes expected serial bits, job shapes
// and results into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tpu_host_link;

  localparam int D_W = 8;
  localparam int N   = 2;
  localparam int WW  = N * D_W;
  localparam int RW  = N * N * 2 * D_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [WW-1:0] op_x_flat = '0;
  logic [WW-1:0] op_y_flat = '0;
  logic          data_in_x, data_in_y, load_en, init;
  logic          data_out_z = 1'b0;
  logic          tx_ready = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [RW-1:0] res_z_flat;
  logic          err_timeout;

  tpu_host_link #(.D_W(D_W), .N(N), .WORD(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_x_flat(op_x_flat), .op_y_flat(op_y_flat),
    .data_in_x(data_in_x), .data_in_y(data_in_y), .load_en(load_en), .init(init),
    .data_out_z(data_out_z), .tx_ready(tx_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_z_flat(res_z_flat),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0]    exp_bits[$];
  logic [RW-1:0] exp_res[$];
  int            exp_seg[$];
  int            exp_gap[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [WW-1:0] x, input logic [WW-1:0] y);
    for (int i = WW - 1; i >= 0; i--) exp_bits.push_back({x[i], y[i]});
  endtask

  task automatic send_word(input logic [WW-1:0] x, input logic [WW-1:0] y);
    int  n = 0;
    bit  done = 0;
    op_x_flat = x;
    op_y_flat = y;
    op_valid  = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      if (op_ready) done = 1;
      @(posedge clk); #1;
      n++;
    end
    op_valid = 1'b0;
    if (!done) check("op_handshake_timeout", 64'(done), 1);
    $display("op word x=%h y=%h accepted=%0d at %0t", x, y, done, $time);
  endtask

  task automatic wait_init();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (init) seen = 1;
      n++;
    end
    if (!seen) check("init_wait_timeout", 64'(seen), 1);
  endtask

  // Feeds the result MSB-first; toggle inserts idle cycles carrying inverted noise on data_out_z.
  task automatic drive_z(input logic [RW-1:0] pat, input bit toggle);
    @(posedge clk); #1;
    for (int i = RW - 1; i >= 0; i--) begin
      tx_ready   = 1'b1;
      data_out_z = pat[i];
      if (i == 0) begin
        @(negedge clk);
        check("res_valid_before_last_bit", 64'(res_valid), 0);
      end
      @(posedge clk); #1;
      if (i == 0) check("res_valid_after_last_bit", 64'(res_valid), 1);
      if (toggle) begin
        tx_ready   = 1'b0;
        data_out_z = ~pat[i];
        @(posedge clk); #1;
      end
    end
    tx_ready   = 1'b0;
    data_out_z = 1'b0;
  endtask

  // Monitor: serial bits, job shape at init, result hold/handshake.
  int   le_cnt = 0, le_seg = 0, le_gap = 0;
  logic prev_le = 1'b0, prev_init = 1'b0, seen_le = 1'b0;

  initial begin
    logic [1:0] b;
    int         es, eg;
    forever begin
      @(negedge clk);
      if (rst) begin
        le_cnt = 0; le_seg = 0; le_gap = 0;
        prev_le = 1'b0; prev_init = 1'b0; seen_le = 1'b0;
      end else begin
        if (load_en) begin
          if (exp_bits.size() == 0) check("unexpected_load_en", 64'(load_en), 0);
          else begin
            b = exp_bits.pop_front();
            check("serial_xy_bits", 64'({data_in_x, data_in_y}), 64'(b));
          end
          if (!prev_le) le_seg++;
          le_cnt++;
          seen_le = 1'b1;
        end else begin
          check("bits_zero_without_load_en", 64'({data_in_x, data_in_y}), 0);
          if (seen_le && !init) begin
            le_gap++;
            check("op_ready_in_gap", 64'(op_ready), 1);
          end
        end
        if (init) begin
          check("init_single_pulse", 64'(prev_init), 0);
          check("init_after_last_bit", 64'(prev_le), 1);
          check("op_ready_at_init", 64'(op_ready), 0);
          if (exp_seg.size() == 0) check("unexpected_init", 64'(init), 0);
          else begin
            es = exp_seg.pop_front();
            eg = exp_gap.pop_front();
            check("load_en_total", 64'(le_cnt), 32);
            check("load_en_segments", 64'(le_seg), 64'(es));
            check("load_en_gap_cycles", 64'(le_gap), 64'(eg));
            $display("job shape: load_en=%0d segments=%0d gap=%0d", le_cnt, le_seg, le_gap);
          end
          le_cnt = 0; le_seg = 0; le_gap = 0; seen_le = 1'b0;
        end
        if (res_valid) begin
          check("op_ready_while_res_valid", 64'(op_ready), 0);
          if (exp_res.size() == 0) check("unexpected_res_valid", 64'(res_valid), 0);
          else begin
            check("res_z_while_valid", res_z_flat, exp_res[0]);
            if (res_ready) begin
              $display("result z=%h expected=%h", res_z_flat, exp_res[0]);
              void'(exp_res.pop_front());
            end
          end
        end
        prev_le   = load_en;
        prev_init = init;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_load_en", 64'(load_en), 0);
    check("reset_init", 64'(init), 0);
    check("reset_data_in", 64'({data_in_x, data_in_y}), 0);
    check("reset_res_valid", 64'(res_valid), 0);
    check("reset_res_z", res_z_flat, 0);
    check("reset_err_timeout", 64'(err_timeout), 0);
    check("reset_op_ready", 64'(op_ready), 1);
    @(posedge clk); #1;

    // Job 1: back-to-back words, tx_ready noise during SHIFT must be ignored.
    exp_seg.push_back(1); exp_gap.push_back(0);
    push_word(16'hA5C3, 16'h0F0F);
    push_word(16'h1234, 16'h8001);
    tx_ready = 1'b1; data_out_z = 1'b1;
    send_word(16'hA5C3, 16'h0F0F);
    send_word(16'h1234, 16'h8001);
    wait_init();
    tx_ready = 1'b0; data_out_z = 1'b0;
    exp_res.push_back(64'hDEADBEEF_01234567);
    drive_z(64'hDEADBEEF_01234567, 1'b0);
    @(posedge clk); #1;
    check("job1_back_to_idle", 64'(op_ready), 1);

    // Job 2: 5-cycle gap between words, paused receive, host stalls result 10 cycles.
    exp_seg.push_back(2); exp_gap.push_back(5);
    push_word(16'h00FF, 16'hF00F);
    push_word(16'h8001, 16'h7FFE);
    send_word(16'h00FF, 16'hF00F);
    repeat (20) @(posedge clk);
    #1;
    send_word(16'h8001, 16'h7FFE);
    res_ready = 1'b0;
    wait_init();
    exp_res.push_back(64'hDEADBEEF_01234567);
    drive_z(64'hDEADBEEF_01234567, 1'b1);
    repeat (10) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk); #1;
    check("job2_res_valid_cleared", 64'(res_valid), 0);
    check("job2_op_ready_after_hs", 64'(op_ready), 1);

    // Job 3: reset during bit 20 of the shift.
    exp_seg.push_back(1); exp_gap.push_back(0);
    push_word(16'hCAFE, 16'hBEEF);
    push_word(16'h5555, 16'hAAAA);
    send_word(16'hCAFE, 16'hBEEF);
    send_word(16'h5555, 16'hAAAA);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_load_en_after_rst", 64'(load_en), 0);
    rst = 1'b0;
    exp_bits.delete(); exp_seg.delete(); exp_gap.delete();
    @(negedge clk);
    check("abort_op_ready_after_release", 64'(op_ready), 1);
    check("abort_load_en_after_release", 64'(load_en), 0);
    check("abort_res_z_cleared", res_z_flat, 0);
    @(posedge clk); #1;

    // Job 4: fresh job after the abort.
    exp_seg.push_back(1); exp_gap.push_back(0);
    push_word(16'hFFFF, 16'h0000);
    push_word(16'h0001, 16'h8000);
    send_word(16'hFFFF, 16'h0000);
    send_word(16'h0001, 16'h8000);
    wait_init();
    exp_res.push_back(64'h01234567_89ABCDEF);
    drive_z(64'h01234567_89ABCDEF, 1'b0);
    @(posedge clk); #1;
    check("job4_back_to_idle", 64'(op_ready), 1);

`ifdef TPU_LINK_TIMEOUT_EN
    begin
      int  n = 0;
      bit  got = 0;
      bit  rv_seen = 0;
      exp_seg.push_back(1); exp_gap.push_back(0);
      push_word(16'h0102, 16'h0304);
      push_word(16'h0506, 16'h0708);
      send_word(16'h0102, 16'h0304);
      send_word(16'h0506, 16'h0708);
      wait_init();
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (res_valid) rv_seen = 1;
        if (err_timeout) begin
          got = 1;
          check("timeout_op_ready_idle", 64'(op_ready), 1);
        end
      end
      check("timeout_pulse_seen", 64'(got), 1);
      check("timeout_cycles_after_init", 64'(n), 17);
      @(negedge clk);
      check("timeout_pulse_one_cycle", 64'(err_timeout), 0);
      check("timeout_no_res_valid", 64'(rv_seen | res_valid), 0);
      $display("timeout job: err_timeout after %0d cycles", n);
    end
`endif

    repeat (3) @(posedge clk);
    check("queues_drained", 64'(exp_bits.size() + exp_res.size() + exp_seg.size()), 0);
    check("no_stray_err_timeout", 64'(err_timeout), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_host_link.md
TPU_HOST_LINK -- requirements
Module: tpu_host_link

Interface
REQ-001 Parameter D_W, default 8, element width in bits.
REQ-002 Parameter N, default 2, systolic array dimension.
REQ-003 Parameter WORD, default 2, operand words per job.
REQ-004 Parameter TIMEOUT_CYC, default 1024, result wait limit in cycles; used only with TPU_LINK_TIMEOUT_EN.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 op_valid  in  1  host operand word valid.
REQ-008 op_ready  out  1  block accepts operand word.
REQ-009 op_x_flat  in  N*D_W  x operand word.
REQ-010 op_y_flat  in  N*D_W  y operand word.
REQ-011 data_in_x  out  1  serial x bit to TPU.
REQ-012 data_in_y  out  1  serial y bit to TPU.
REQ-013 load_en  out  1  serial bits valid to TPU.
REQ-014 init  out  1  one-cycle compute-start pulse to TPU.
REQ-015 data_out_z  in  1  serial result bit from TPU.
REQ-016 tx_ready  in  1  data_out_z valid this cycle.
REQ-017 res_valid  out  1  result word valid to host.
REQ-018 res_ready  in  1  host accepts result.
REQ-019 res_z_flat  out  N*N*2*D_W  packed result.
REQ-020 err_timeout  out  1  one-cycle pulse on result timeout.

Function
REQ-021 FSM states SHALL be IDLE, SHIFT, INIT, WAIT_Z, RECV, HOLD.
REQ-022 IDLE: op_ready=1; handshake (op_valid&&op_ready) latches both words into shift registers, word counter=0, -> SHIFT.
REQ-023 SHIFT: load_en=1; data_in_x/data_in_y driven MSB-first (bit N*D_W-1 first), one bit per cycle, first bit the cycle after the handshake, N*D_W cycles per word.
REQ-024 During the last bit cycle of a non-final word, op_ready=1; handshake there loads the next word with no load_en gap.
REQ-025 If no handshake at a non-final word boundary, load_en=0 and bit outputs=0 until op_valid; op_ready=1 in that gap; SHIFT resumes the cycle after the handshake.
REQ-026 After last bit of word WORD-1 -> INIT: init=1 for exactly one cycle, load_en=0, op_ready=0.
REQ-027 INIT -> WAIT_Z; in WAIT_Z, RECV, HOLD op_ready=0.
REQ-028 WAIT_Z/RECV: each cycle tx_ready=1 shifts data_out_z into res_z_flat LSB, shifting left (first bit ends at MSB); bit counter increments.
REQ-029 tx_ready=0 in RECV pauses capture; counter holds.
REQ-030 On the N*N*2*D_W-th captured bit -> HOLD; res_valid=1 next cycle.
REQ-031 HOLD: res_z_flat stable while res_valid=1; res_valid&&res_ready -> IDLE, res_valid=0 next cycle.
REQ-032 tx_ready outside WAIT_Z/RECV SHALL be ignored.
REQ-033 data_in_x, data_in_y SHALL be 0 whenever load_en=0.

Reset
REQ-034 rst=1 at any state, mid-shift or mid-receive, -> IDLE next edge; op_ready=1 after release.
REQ-035 Reset values: load_en=0, init=0, data_in_x=0, data_in_y=0, res_valid=0, res_z_flat=0, err_timeout=0, all counters 0.

Configuration
REQ-036 Macro TPU_LINK_TIMEOUT_EN defined: WAIT_Z cycle counter; TIMEOUT_CYC cycles in WAIT_Z without tx_ready -> err_timeout=1 one cycle, -> IDLE, no res_valid.
REQ-037 Macro undefined: no counter, WAIT_Z waits indefinitely, err_timeout tied 0.

Structure
REQ-038 Shared package tpu_pkg SHALL hold FSM state encoding and defaults for D_W, N, WORD.
REQ-039 One sub-module tpu_link_ser: parallel-load MSB-first shift register with bit counter, instanced for x and y.

Verification
REQ-040 Reset then op words x=16'hA5C3,y=16'h0F0F, then 16'h1234,16'h8001 back-to-back -> load_en high 32 continuous cycles, first x bits 1,0,1,0; init single pulse the cycle after.
REQ-041 Second word delayed 5 cycles -> load_en low 5 cycles, bits 0, op_ready high during gap, total load_en=32.
REQ-042 tx_ready high 64 cycles, data_out_z pattern 64'hDEADBEEF_01234567 MSB-first -> res_z_flat=64'hDEADBEEF01234567, res_valid 1 cycle after last bit.
REQ-043 tx_ready toggled 1/0 during receive with res_ready low 10 cycles -> same result, res_valid stable, op_ready 0 until handshake.
REQ-044 rst asserted at bit 20 of shift -> next cycle load_en=0, op_ready=1 after release; fresh job completes correctly.
REQ-045 With TPU_LINK_TIMEOUT_EN, TIMEOUT_CYC=16, tx_ready held 0 -> err_timeout pulse 16 cycles after entering WAIT_Z, IDLE, res_valid never asserted.
